// File: rtl/prio_arbiter.sv
// prio_arbiter: N-way request arbiter with a registered grant and a
// valid/ready handshake. Arbitration searches downward from a priority
// pointer, wrapping from index 0 to N-1; the first set request bit wins.
//
// Configuration macro: PRIO_ARBITER_RR_MODE_EN
//   undefined (default) : fixed priority, pointer tied to N-1 (highest index wins)
//   defined             : round-robin, pointer moves to (winner-1) mod N after
//                         every completed handshake
module prio_arbiter #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         ready,
  output logic [W-1:0] out,
  output logic [N-1:0] onehot,
  output logic         valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] out_next;
  logic [N-1:0] onehot_next;
  logic [W-1:0] arb_ptr;
  logic [W-1:0] winner;
  logic [W-1:0] idx;
  logic         found;
  logic         handshake;

  assign valid     = (state == OFFER);
  assign handshake = valid & ready;

`ifdef PRIO_ARBITER_RR_MODE_EN
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_after;

  // Priority drops to just below the index being accepted this cycle.
  assign ptr_after = (out == '0) ? W'(N - 1) : out - 1'b1;

  // Round-robin pointer: advances only on a completed handshake.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (handshake) begin
      ptr <= ptr_after;
    end
  end

  // Re-arbitration in the handshake edge must already see the updated pointer.
  assign arb_ptr = handshake ? ptr_after : ptr;
`else
  // Fixed priority: the search always starts at the highest index.
  assign arb_ptr = W'(N - 1);
`endif

  // Downward wrapping search from arb_ptr; index never leaves 0..N-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = arb_ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && in[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = (idx == '0) ? W'(N - 1) : idx - 1'b1;
    end
  end

  // Next-state and next-grant logic for the IDLE/OFFER handshake FSM.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    out_next    = out;
    onehot_next = onehot;
    case (state)
      IDLE: begin
        onehot_next = '0;
        if (|in) begin
          state_next          = OFFER;
          out_next            = winner;
          onehot_next[winner] = 1'b1;
        end
      end
      OFFER: begin
        if (ready) begin
          onehot_next = '0;
          if (|in) begin
            out_next            = winner;
            onehot_next[winner] = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        onehot_next = '0;
      end
    endcase
  end

  // State and registered grant; reset drops any pending grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      onehot <= '0;
    end else begin
      state  <= state_next;
      out    <= out_next;
      onehot <= onehot_next;
    end
  end

endmodule
